// File: rtl/f_stage.sv
// f_stage: MIPS fetch stage; pc register drives i_inst_addr/f_pc, resolves decode-stage branch/jump targets (delay slot), outputs f_instr, d_link_pc, f_redirect
module f_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_rs_data,
  input  logic [31:0] d_rt_data,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [31:0] d_link_pc,
  output logic        f_redirect
);
  logic [31:0] pc_q, pc_d, d_pc4, br_tgt, j_tgt, tgt;
  logic [5:0] op, funct;
  logic is_beq, is_bne, is_j, is_jr, taken;
  assign op     = d_instr[31:26];
  assign funct  = d_instr[5:0];
  assign d_pc4  = d_pc + 32'd4;
  assign br_tgt = d_pc4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
  assign j_tgt  = {d_pc4[31:28], d_instr[25:0], 2'b00};
  assign is_beq = op == 6'b000100;
  assign is_bne = op == 6'b000101;
  assign is_j   = op == 6'b000010 || op == 6'b000011;
  assign is_jr  = op == 6'b000000 && (funct == 6'b001000 || funct == 6'b001001);
  assign taken  = (is_beq && d_rs_data == d_rt_data) || (is_bne && d_rs_data != d_rt_data) || is_j || is_jr;
  assign tgt    = is_jr ? d_rs_data : is_j ? j_tgt : br_tgt;
  assign f_redirect  = taken && !stall;
  assign pc_d        = stall ? pc_q : f_redirect ? tgt : pc_q + 32'd4;
  assign i_inst_addr = pc_q;
  assign f_pc        = pc_q;
  assign f_instr     = i_inst_rdata;
  assign d_link_pc   = d_pc + 32'd8;
  always_ff @(posedge clk)
    pc_q <= reset ? RESET_PC : pc_d;
endmodule
